// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR MAC sequencer.
package fir_ctrl_pkg;

    // Controller states; FLUSH is the reset state.
    typedef enum logic [2:0] {
        StFlush,
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StHold
    } fir_ctrl_state_t;

    localparam int unsigned DEF_TAPS  = 80;
    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_BEATS = DEF_TAPS / DEF_LANES;

    // Address width for a TAPS-deep delay line.
    function automatic int unsigned calc_aw(input int unsigned taps);
        return $clog2(taps);
    endfunction

    // Number of MAC beats per output sample.
    function automatic int unsigned calc_beats(input int unsigned taps, input int unsigned lanes);
        return taps / lanes;
    endfunction

    // Counter width that stays at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a - b) mod m for a < m and b < m: a single conditional add of m, no divider.
    function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) begin
            d = d + int'(m);
        end
        return unsigned'(d);
    endfunction

endpackage

// File: rtl/fir_sched_ctrl_addr_gen.sv
// Per-lane circular delay-line read-address generator (module fir_addr_gen).
// Lane k of beat b reads (base - (LANES*b + k)) mod TAPS.
module fir_addr_gen
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned TAPS  = DEF_TAPS,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned AW    = calc_aw(DEF_TAPS),
    parameter int unsigned BW    = cnt_width(DEF_BEATS)
) (
    input  logic [AW-1:0]       base,
    input  logic [BW-1:0]       beat,
    output logic [LANES*AW-1:0] raddr
);

    // One wrapped address per lane, newest sample first.
    always_comb begin
        raddr = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            raddr[k*AW +: AW] = AW'(mod_sub(32'(base), LANES * 32'(beat) + 32'(k), TAPS));
        end
    end

endmodule

// File: rtl/fir_sched_ctrl.sv
// Sequencer for the 4-lane FIR MAC datapath: delay-line flush, sample load, beat issue,
// result capture and host coefficient writes.
// Optional feature: define FIR_CTRL_DBL_BANK_EN for double-buffered coefficient banks.
module fir_sched_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned TAPS  = 80,
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 8,
    parameter int unsigned PIPE  = 2,
    localparam int unsigned AW   = calc_aw(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 dl_we,
    output logic [AW-1:0]        dl_waddr,
    output logic signed [DW-1:0] dl_wdata,
    output logic [LANES*AW-1:0]  dl_raddr,
    output logic [AW-1:0]        coef_raddr,
    output logic                 coef_bank,
    output logic                 mac_en,
    output logic                 mac_clr,
    output logic                 mac_last,
    input  logic signed [DW-1:0] res_in,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [CW-1:0] cfg_wdata,
    input  logic                 cfg_swap,
    output logic                 cfg_ready,
    output logic                 coef_we,
    output logic [AW:0]          coef_waddr,
    output logic signed [CW-1:0] coef_wdata,
    output logic                 busy
);

    localparam int unsigned BEATS = calc_beats(TAPS, LANES);
    localparam int unsigned BW    = cnt_width(BEATS);
    localparam int unsigned PW    = cnt_width(PIPE);

    fir_ctrl_state_t state;
    logic [AW:0]     fcnt;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   base;
    logic [BW-1:0]   beat;
    logic [PW-1:0]   dcnt;
    logic            accept;
    logic            bank_sel;

    // Handshake/status flags derive only from the state register.
    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);
    assign accept   = (state == StIdle) && in_valid;

    fir_addr_gen #(
        .TAPS  (TAPS),
        .LANES (LANES),
        .AW    (AW),
        .BW    (BW)
    ) u_addr_gen (
        .base  (base),
        .beat  (beat),
        .raddr (dl_raddr)
    );

    // Main sequencer with registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StFlush;
            fcnt       <= '0;
            wptr       <= '0;
            base       <= '0;
            beat       <= '0;
            dcnt       <= '0;
            dl_we      <= 1'b0;
            dl_waddr   <= '0;
            dl_wdata   <= '0;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            mac_last   <= 1'b0;
            coef_raddr <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                StFlush: begin
                    if (fcnt < (AW+1)'(TAPS)) begin
                        dl_we    <= 1'b1;
                        dl_waddr <= AW'(fcnt);
                        dl_wdata <= '0;
                        fcnt     <= fcnt + (AW+1)'(1);
                    end else begin
                        dl_we <= 1'b0;
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    if (in_valid) begin
                        // The write strobe issued here is the LOAD-cycle delay-line write.
                        dl_we    <= 1'b1;
                        dl_waddr <= wptr;
                        dl_wdata <= in_data;
                        base     <= wptr;
                        wptr     <= (wptr == AW'(TAPS - 1)) ? '0 : wptr + AW'(1);
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    dl_we      <= 1'b0;
                    mac_en     <= 1'b1;
                    mac_clr    <= 1'b1;
                    mac_last   <= (BEATS == 1);
                    beat       <= '0;
                    coef_raddr <= '0;
                    state      <= StRun;
                end
                StRun: begin
                    mac_clr <= 1'b0;
                    if (beat == BW'(BEATS - 1)) begin
                        mac_en   <= 1'b0;
                        mac_last <= 1'b0;
                        dcnt     <= '0;
                        state    <= StDrain;
                    end else begin
                        beat       <= beat + BW'(1);
                        mac_last   <= (beat == BW'(BEATS - 2));
                        coef_raddr <= coef_raddr + AW'(LANES);
                    end
                end
                StDrain: begin
                    if (dcnt == PW'(PIPE - 1)) begin
                        out_data  <= res_in;
                        out_valid <= 1'b1;
                        state     <= StHold;
                    end else begin
                        dcnt <= dcnt + PW'(1);
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StFlush;
            endcase
        end
    end

`ifdef FIR_CTRL_DBL_BANK_EN
    logic swap_pending;

    assign cfg_ready = (state != StFlush);
    // Host writes always land in the bank the datapath is not reading.
    assign bank_sel  = ~coef_bank;

    // Bank swaps only take effect on an accept so one sample never straddles banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_bank    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (accept) begin
            coef_bank    <= coef_bank ^ swap_pending;
            swap_pending <= cfg_swap;
        end else begin
            swap_pending <= swap_pending | cfg_swap;
        end
    end
`else
    logic unused_cfg;

    assign cfg_ready  = (state == StIdle);
    assign bank_sel   = 1'b0;
    assign coef_bank  = 1'b0;
    assign unused_cfg = cfg_swap ^ accept;
`endif

    // Host coefficient write port; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_we    <= 1'b0;
            coef_waddr <= '0;
            coef_wdata <= '0;
        end else begin
            coef_we <= cfg_we && cfg_ready && ({1'b0, cfg_addr} < (AW+1)'(TAPS));
            if (cfg_we && cfg_ready) begin
                coef_waddr <= {bank_sel, cfg_addr};
                coef_wdata <= cfg_wdata;
            end
        end
    end

endmodule
